// File: rtl/rr_chan_sequencer.sv
// Round-robin channel sequencer placed in front of the receiver data MUX.
// It collects per-channel burst-ready strobes and grants one channel at a
// time. For each burst it steps the MUX select and word index, captures every
// MUX word and hands it downstream over a valid/ready handshake. It pulses
// ack for the channel once the whole burst has been delivered.
module rr_chan_sequencer #(
  parameter int SEL   = 4,
  parameter int WIDTH = 24,
  parameter int WORDS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL-1:0]             req,
  output logic [$clog2(SEL)-1:0]     sel,
  output logic [$clog2(WORDS):0]     word_idx,
  input  logic [WIDTH-1:0]           mux_out,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL-1:0]             ack,
  output logic [SEL-1:0]             overrun,
  output logic                       busy
);

  localparam int SEL_W = $clog2(SEL);
  localparam int IDX_W = $clog2(WORDS) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  logic [1:0]       state;
  logic [SEL-1:0]   pending;
  logic [SEL_W-1:0] ptr;

  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;
  logic             handshake;
  logic             last_word;
  logic [SEL-1:0]   clear_vec;

  assign handshake = (state == ST_XFER) && out_valid && out_ready;
  assign last_word = (word_idx == IDX_W'(WORDS - 1));
  // The granted channel's pending bit drops on the same edge that raises its ack.
  assign clear_vec = (handshake && last_word) ? (SEL'(1) << sel) : '0;
  assign busy      = (state != ST_IDLE);

  // Search upward from ptr (wrapping) for the first pending channel.
  always_comb begin
    logic [SEL_W-1:0] cand;
    // NOTE: every variable gets a value before any conditional logic, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < SEL; i++) begin
      cand = SEL_W'((int'(ptr) + i) % SEL);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Track pending bursts and flag a sticky overrun on a strobe for a channel that is still waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so that every flop samples pre-edge values.
      // A fresh req wins over the clear, so a strobe in the completing cycle starts a new burst.
      pending <= (pending & ~clear_vec) | req;
      overrun <= overrun | (req & pending & ~clear_vec);
    end
  end

  // Sequence IDLE -> SETUP -> XFER, capturing one MUX word for each SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= '0;
      word_idx  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      ack       <= '0;
      ptr       <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            sel      <= grant_idx;
            word_idx <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // sel/word_idx have been stable for a full cycle, so the MUX output has settled.
          out_data  <= mux_out;
          out_valid <= 1'b1;
          state     <= ST_XFER;
        end
        ST_XFER: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (!last_word) begin
              word_idx <= word_idx + IDX_W'(1);
              state    <= ST_SETUP;
            end else begin
              ack   <= SEL'(1) << sel;
              ptr   <= (sel == SEL_W'(SEL - 1)) ? '0 : sel + SEL_W'(1);
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_chan_sequencer.sv
// Directed bench for rr_chan_sequencer (SEL=4, WIDTH=24, WORDS=2). A small
// behavioural MUX returns a distinct word for each (sel, word_idx) pair.
module tb_rr_chan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [1:0]  sel;
  logic [1:0]  word_idx;
  logic [23:0] mux_out;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  ack;
  logic [3:0]  overrun;
  logic        busy;

  logic [23:0] noise = '0;
  int compared   = 0;
  int mismatched = 0;
  int hs_count   = 0;
  int hs_mark    = 0;
  int ack_pulses = 0;

  rr_chan_sequencer #(.SEL(4), .WIDTH(24), .WORDS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sel       (sel),
    .word_idx  (word_idx),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] data_of(input logic [1:0] ch, input logic [1:0] w);
    return 24'hA00000 | {10'b0, ch, 10'b0, w};
  endfunction

  assign mux_out = data_of(sel, word_idx) ^ noise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count accepted words and confirm each carries the word the MUX offered for that grant.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_count++;
      check("hs_data", {8'h0, out_data}, {8'h0, data_of(sel, word_idx)});
    end
    if (ack != 4'b0) ack_pulses++;
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    noise     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    hs_mark = hs_count;
  endtask

  // Wait (bounded) for the next ack, then check which channel finished and how many words it took.
  task automatic wait_ack(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack != 4'b0) break;
    end
    check({tag, "_ack"}, {28'h0, ack}, {28'h0, exp});
    check({tag, "_words"}, hs_count - hs_mark, 2);
    hs_mark = hs_count;
  endtask

  initial begin
    // Reset state, sampled while rst_n is held low.
    #12;
    check("rst_sel", {30'h0, sel}, 0);
    check("rst_word_idx", {30'h0, word_idx}, 0);
    check("rst_out_data", {8'h0, out_data}, 0);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_ack", {28'h0, ack}, 0);
    check("rst_overrun", {28'h0, overrun}, 0);
    check("rst_busy", {31'h0, busy}, 0);

    // 1. Single burst on channel 2, exact cycle timing.
    do_reset();
    req = 4'b0100;                       // cycle 0
    tick(); req = '0;                    // cycle 1
    check("t1_c1_busy", {31'h0, busy}, 0);
    tick();                              // cycle 2
    check("t1_c2_busy", {31'h0, busy}, 1);
    check("t1_c2_sel", {30'h0, sel}, 2);
    check("t1_c2_valid", {31'h0, out_valid}, 0);
    tick();                              // cycle 3
    check("t1_c3_valid", {31'h0, out_valid}, 1);
    check("t1_c3_idx", {30'h0, word_idx}, 0);
    check("t1_c3_data", {8'h0, out_data}, 24'hA02000);
    tick();                              // cycle 4
    check("t1_c4_valid", {31'h0, out_valid}, 0);
    check("t1_c4_idx", {30'h0, word_idx}, 1);
    tick();                              // cycle 5
    check("t1_c5_valid", {31'h0, out_valid}, 1);
    check("t1_c5_data", {8'h0, out_data}, 24'hA02001);
    check("t1_c5_ack", {28'h0, ack}, 0);
    tick();                              // cycle 6
    check("t1_c6_ack", {28'h0, ack}, 4'b0100);
    check("t1_c6_busy", {31'h0, busy}, 0);
    tick();                              // cycle 7
    check("t1_c7_ack", {28'h0, ack}, 0);
    check("t1_words", hs_count - hs_mark, 2);

    // 2. Fairness from reset: all four at once, then channels 0 and 3 together.
    do_reset();
    req = 4'b1111;
    tick(); req = '0;
    wait_ack("t2_a", 4'b0001);
    wait_ack("t2_b", 4'b0010);
    wait_ack("t2_c", 4'b0100);
    wait_ack("t2_d", 4'b1000);
    req = 4'b1001;
    tick(); req = '0;
    wait_ack("t2_e", 4'b0001);
    wait_ack("t2_f", 4'b1000);

    // 3. Backpressure on the first word of channel 1 while the MUX output wanders.
    out_ready = 1'b0;
    req = 4'b0010;                       // cycle 0
    tick(); req = '0;
    tick();
    tick();                              // cycle 3
    check("t3_valid", {31'h0, out_valid}, 1);
    check("t3_data", {8'h0, out_data}, 24'hA01000);
    for (int k = 1; k <= 10; k++) begin
      noise = 24'h111111 * k[23:0];
      tick();
      check("t3_hold_valid", {31'h0, out_valid}, 1);
      check("t3_hold_data", {8'h0, out_data}, 24'hA01000);
    end
    noise = '0;
    out_ready = 1'b1;
    wait_ack("t3", 4'b0010);

    // 4. Overrun: a second strobe while pending, then a strobe in the ack cycle.
    do_reset();
    check("t4_ovr_init", {28'h0, overrun}, 0);
    req = 4'b0010;                       // cycle 0
    tick(); req = 4'b0010;               // cycle 1, channel 1 still pending
    tick(); req = '0;                    // cycle 2
    check("t4_ovr_set", {28'h0, overrun}, 4'b0010);
    wait_ack("t4_first", 4'b0010);
    req = 4'b0010;                       // strobe while ack is high
    tick(); req = '0;
    check("t4_ovr_keep", {28'h0, overrun}, 4'b0010);
    wait_ack("t4_second", 4'b0010);
    repeat (8) tick();
    check("t4_no_third", hs_count - hs_mark, 0);
    check("t4_idle", {31'h0, busy}, 0);
    check("t4_ovr_end", {28'h0, overrun}, 4'b0010);

    // 5. Asynchronous reset in the middle of a channel-2 transfer.
    out_ready = 1'b0;
    req = 4'b0100;
    tick(); req = '0;
    tick();
    tick();
    check("t5_in_xfer", {31'h0, out_valid}, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_sel", {30'h0, sel}, 0);
    check("t5_idx", {30'h0, word_idx}, 0);
    check("t5_data", {8'h0, out_data}, 0);
    check("t5_valid", {31'h0, out_valid}, 0);
    check("t5_ack", {28'h0, ack}, 0);
    check("t5_ovr", {28'h0, overrun}, 0);
    check("t5_busy", {31'h0, busy}, 0);
    ack_pulses = 0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    hs_mark = hs_count;
    repeat (10) tick();
    check("t5_no_ack", ack_pulses, 0);
    check("t5_no_words", hs_count - hs_mark, 0);
    check("t5_idle", {31'h0, busy}, 0);

    // 6. Wrap: after serving channel 2 the pointer is 3; channels 0 and 3 pending.
    req = 4'b0100;
    tick(); req = '0;
    wait_ack("t6_pre", 4'b0100);
    req = 4'b1001;
    tick(); req = '0;
    wait_ack("t6_a", 4'b1000);
    wait_ack("t6_b", 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
